qedmma_corr_peak_detect: RTL and testbench

//  Downstream stage of the correlator PISO serializer. Consumes the per-lane AXI-Stream

---
 rtl/qedmma_corr_peak_detect.sv | 176 +++++++++++++++++
 tb/tb_qedmma_corr_peak_detect.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qedmma_corr_peak_detect.sv
// rtl/qedmma_corr_peak_detect.sv - correlator frame forwarder with per-frame peak / threshold report
// Beats pass through a 1-deep slice untouched; analysis runs on accepted beats only.
module qedmma_corr_peak_detect #(
  parameter int NUM_LANES      = 512,
  parameter int ACC_WIDTH      = 48,
  parameter int LANE_WIDTH     = 10,
  parameter int AXI_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  input  logic [ACC_WIDTH-1:0]      i_threshold,
  output logic                      o_report_valid,
  output logic [LANE_WIDTH-1:0]     o_peak_lane,
  output logic [ACC_WIDTH-1:0]      o_peak_mag,
  output logic [LANE_WIDTH-1:0]     o_det_count,
  output logic                      o_frame_err,
  output logic                      o_busy
);

  localparam logic [LANE_WIDTH-1:0] CNT_ONE   = LANE_WIDTH'(1);
  localparam logic [LANE_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [LANE_WIDTH-1:0] FRAME_LEN = LANE_WIDTH'(NUM_LANES);
  localparam logic [ACC_WIDTH-1:0]  MAG_MAX   = {1'b0, {(ACC_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_REPORT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ACC_WIDTH-1:0]  r_thr_q;
  logic [ACC_WIDTH-1:0]  r_peak_mag;
  logic [LANE_WIDTH-1:0] r_peak_lane;
  logic [LANE_WIDTH-1:0] r_det_cnt;
  logic [LANE_WIDTH-1:0] r_beat_cnt;
  logic                  r_seq_err;

  logic                  w_accept;
  logic                  w_slice_free;
  logic                  w_first;
  logic [ACC_WIDTH-1:0]  w_acc;
  logic [LANE_WIDTH-1:0] w_lane;
  logic [ACC_WIDTH-1:0]  w_mag;
  logic [LANE_WIDTH-1:0] w_exp_lane;
  logic [LANE_WIDTH-1:0] w_cnt_nxt;
  logic                  w_hit;
  logic [LANE_WIDTH-1:0] w_det_base;
  logic [LANE_WIDTH-1:0] w_det_nxt;
  logic                  w_take;
  logic [ACC_WIDTH-1:0]  w_peak_mag_nxt;
  logic [LANE_WIDTH-1:0] w_peak_lane_nxt;
  logic                  w_seq_nxt;
  logic                  w_err_nxt;

  // The slice can take a beat when empty or when its current beat leaves this cycle.
  assign w_slice_free  = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (r_state != ST_REPORT) && w_slice_free;
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign o_busy        = (r_state != ST_IDLE);

  assign w_acc  = s_axis_tdata[ACC_WIDTH-1:0];
  assign w_lane = s_axis_tdata[ACC_WIDTH+LANE_WIDTH-1:ACC_WIDTH];

  // Most-negative accumulator has no positive twin; clamp it.
  always_comb begin
    w_mag = w_acc;
    if (w_acc[ACC_WIDTH-1]) begin
      w_mag = (w_acc[ACC_WIDTH-2:0] == '0) ? MAG_MAX : -w_acc;
    end
  end

  // Next-state of the frame statistics; in IDLE the accepted beat starts a fresh frame.
  always_comb begin
    w_first         = (r_state == ST_IDLE);
    w_exp_lane      = w_first ? '0 : r_beat_cnt;
    w_cnt_nxt       = w_first ? CNT_ONE :
                      ((r_beat_cnt == CNT_MAX) ? CNT_MAX : r_beat_cnt + CNT_ONE);
    w_hit           = (w_mag >= (w_first ? i_threshold : r_thr_q));
    w_det_base      = w_first ? '0 : r_det_cnt;
    w_det_nxt       = (w_hit && (w_det_base != CNT_MAX)) ? w_det_base + CNT_ONE : w_det_base;
    w_take          = w_first || (w_mag > r_peak_mag);
    w_peak_mag_nxt  = w_take ? w_mag : r_peak_mag;
    w_peak_lane_nxt = w_take ? w_lane : r_peak_lane;
    w_seq_nxt       = (!w_first && r_seq_err) || (w_lane != w_exp_lane);
    w_err_nxt       = w_seq_nxt || (w_cnt_nxt != FRAME_LEN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    o_report_valid = 1'b0;
    case (r_state)
      ST_IDLE, ST_ACCUM: begin
        if (w_accept) begin
          w_state_nxt = s_axis_tlast ? ST_REPORT : ST_ACCUM;
        end
      end
      ST_REPORT: begin
        o_report_valid = 1'b1;
        w_state_nxt    = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (w_accept) begin
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tlast  <= s_axis_tlast;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_thr_q     <= '0;
      r_peak_mag  <= '0;
      r_peak_lane <= '0;
      r_det_cnt   <= '0;
      r_beat_cnt  <= '0;
      r_seq_err   <= 1'b0;
    end else if (w_accept) begin
      if (w_first) begin
        r_thr_q <= i_threshold;
      end
      r_peak_mag  <= w_peak_mag_nxt;
      r_peak_lane <= w_peak_lane_nxt;
      r_det_cnt   <= w_det_nxt;
      r_beat_cnt  <= w_cnt_nxt;
      r_seq_err   <= w_seq_nxt;
    end else if (r_state == ST_REPORT) begin
      r_beat_cnt <= '0;
      r_seq_err  <= 1'b0;
    end
  end

  // Report fields are captured with the closing beat and held until the next frame closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_peak_lane <= '0;
      o_peak_mag  <= '0;
      o_det_count <= '0;
      o_frame_err <= 1'b0;
    end else if (w_accept && s_axis_tlast) begin
      o_peak_lane <= w_peak_lane_nxt;
      o_peak_mag  <= w_peak_mag_nxt;
      o_det_count <= w_det_nxt;
      o_frame_err <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_qedmma_corr_peak_detect.sv
// tb/tb_qedmma_corr_peak_detect.sv - directed bench for the correlator peak detector
module tb_qedmma_corr_peak_detect;

  logic        clk;
  logic        rst_n;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [47:0] i_threshold;
  logic        o_report_valid;
  logic [9:0]  o_peak_lane;
  logic [47:0] o_peak_mag;
  logic [9:0]  o_det_count;
  logic        o_frame_err;
  logic        o_busy;

  qedmma_corr_peak_detect dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
    .i_threshold    (i_threshold),
    .o_report_valid (o_report_valid),
    .o_peak_lane    (o_peak_lane),
    .o_peak_mag     (o_peak_mag),
    .o_det_count    (o_det_count),
    .o_frame_err    (o_frame_err),
    .o_busy         (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] stim [0:1023];
  logic [64:0] out_q [$];
  int          rep_cnt, first_acc_cyc, first_mv_cyc, tlast_cyc, rep_cyc;
  logic [9:0]  rep_lane, rep_det;
  logic [47:0] rep_mag;
  logic        rep_err;

  function automatic logic [63:0] beat(input int lane, input logic [47:0] acc);
    logic [9:0] l;
    l = lane[9:0];
    return {6'b0, l, acc};
  endfunction

  // Drives one frame with optional valid gaps / ready throttling and records everything seen.
  task automatic run_frame(input int len, input int vgap, input int rpct,
                           input logic [47:0] thr, input logic [47:0] thr_mid, input int abort_at);
    int   idx;
    int   cyc;
    logic hs;
    out_q.delete();
    rep_cnt = 0; first_acc_cyc = -1; first_mv_cyc = -1; tlast_cyc = -1; rep_cyc = -1;
    idx = 0; cyc = 0; hs = 1'b0;
    while (cyc < 20000) begin
      @(negedge clk);
      if (hs) s_axis_tvalid = 1'b0;
      if (!s_axis_tvalid && idx < len) s_axis_tvalid = ($urandom_range(0, 99) >= vgap);
      s_axis_tdata  = stim[idx];
      s_axis_tlast  = (idx == len - 1);
      i_threshold   = (idx >= len / 2) ? thr_mid : thr;
      m_axis_tready = ($urandom_range(0, 99) < rpct);
      #1;
      hs = s_axis_tvalid && s_axis_tready;
      if (m_axis_tvalid && first_mv_cyc < 0) first_mv_cyc = cyc;
      if (m_axis_tvalid && m_axis_tready) out_q.push_back({m_axis_tlast, m_axis_tdata});
      if (o_report_valid) begin
        rep_cnt++; rep_cyc = cyc;
        rep_lane = o_peak_lane; rep_mag = o_peak_mag; rep_det = o_det_count; rep_err = o_frame_err;
      end
      if (hs) begin
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        if (s_axis_tlast) tlast_cyc = cyc;
        idx++;
      end
      cyc++;
      if (abort_at >= 0 && idx == abort_at) break;
      if (idx == len && rep_cnt > 0 && out_q.size() >= len) break;
    end
    if (cyc >= 20000) begin
      $display("FAIL frame_timeout accepted %0d of %0d beats, reports %0d", idx, len, rep_cnt);
      n_err++; n_vec++;
    end
    if (abort_at < 0) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        #1;
        if (o_report_valid) rep_cnt++;
        if (m_axis_tvalid && m_axis_tready) out_q.push_back({m_axis_tlast, m_axis_tdata});
      end
    end
  endtask

  task automatic fill_ramp(input int len);
    for (int i = 0; i < len; i++) stim[i] = beat(i, 48'(i));
  endtask

  task automatic test_reset;
    rst_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0;
    m_axis_tready = 1'b1; i_threshold = '0;
    repeat (3) @(negedge clk);
    #1;
    if (m_axis_tvalid !== 1'b0) begin $display("FAIL rst_mvalid got %b want 0", m_axis_tvalid); n_err++; end n_vec++;
    if (o_report_valid !== 1'b0) begin $display("FAIL rst_report got %b want 0", o_report_valid); n_err++; end n_vec++;
    if (o_busy !== 1'b0) begin $display("FAIL rst_busy got %b want 0", o_busy); n_err++; end n_vec++;
    if (o_peak_mag !== 48'd0 || o_det_count !== 10'd0 || o_frame_err !== 1'b0)
      begin $display("FAIL rst_fields got mag %0h det %0d err %b want 0", o_peak_mag, o_det_count, o_frame_err); n_err++; end n_vec++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_full_frame;
    int bad;
    fill_ramp(512);
    run_frame(512, 0, 100, 48'd500, 48'd0, -1);
    if (rep_lane !== 10'd511) begin $display("FAIL t1_lane got %0d want 511", rep_lane); n_err++; end n_vec++;
    if (rep_mag !== 48'd511) begin $display("FAIL t1_mag got %0d want 511", rep_mag); n_err++; end n_vec++;
    if (rep_det !== 10'd12) begin $display("FAIL t1_det got %0d want 12", rep_det); n_err++; end n_vec++;
    if (rep_err !== 1'b0) begin $display("FAIL t1_err got %b want 0", rep_err); n_err++; end n_vec++;
    if (rep_cnt != 1) begin $display("FAIL t1_reports got %0d want 1", rep_cnt); n_err++; end n_vec++;
    if (first_mv_cyc != first_acc_cyc + 1) begin $display("FAIL t1_latency got cyc %0d want %0d", first_mv_cyc, first_acc_cyc + 1); n_err++; end n_vec++;
    if (rep_cyc != tlast_cyc + 1) begin $display("FAIL t1_report_cyc got %0d want %0d", rep_cyc, tlast_cyc + 1); n_err++; end n_vec++;
    if (out_q.size() != 512) begin $display("FAIL t1_out_count got %0d want 512", out_q.size()); n_err++; end n_vec++;
    bad = 0;
    for (int i = 0; i < out_q.size() && i < 512; i++) begin
      if (out_q[i] !== {(i == 511), stim[i]}) begin
        if (bad < 4) $display("FAIL t1_beat%0d got %h want %h", i, out_q[i], {(i == 511), stim[i]});
        bad++; n_err++;
      end
      n_vec++;
    end
  endtask

  task automatic test_negative_peak;
    int bad;
    for (int i = 0; i < 512; i++) stim[i] = beat(i, (i == 100) ? -48'sd1000 : 48'd5);
    for (int i = 0; i < 512; i++) stim[i][63:58] = 6'h2A;
    run_frame(512, 10, 80, 48'd6, 48'd6, -1);
    if (rep_lane !== 10'd100) begin $display("FAIL t2_lane got %0d want 100", rep_lane); n_err++; end n_vec++;
    if (rep_mag !== 48'd1000) begin $display("FAIL t2_mag got %0d want 1000", rep_mag); n_err++; end n_vec++;
    if (rep_det !== 10'd1) begin $display("FAIL t2_det got %0d want 1", rep_det); n_err++; end n_vec++;
    if (rep_err !== 1'b0) begin $display("FAIL t2_err got %b want 0", rep_err); n_err++; end n_vec++;
    bad = 0;
    for (int i = 0; i < out_q.size() && i < 512; i++) begin
      if (out_q[i][63:0] !== stim[i]) begin
        if (bad < 4) $display("FAIL t2_beat%0d got %h want %h", i, out_q[i][63:0], stim[i]);
        bad++; n_err++;
      end
      n_vec++;
    end
  endtask

  task automatic test_tie;
    for (int i = 0; i < 512; i++) stim[i] = beat(i, (i == 3 || i == 7) ? 48'd42 : 48'd1);
    run_frame(512, 0, 100, 48'd42, 48'd42, -1);
    if (rep_lane !== 10'd3) begin $display("FAIL t3_lane got %0d want 3", rep_lane); n_err++; end n_vec++;
    if (rep_mag !== 48'd42) begin $display("FAIL t3_mag got %0d want 42", rep_mag); n_err++; end n_vec++;
    if (rep_det !== 10'd2) begin $display("FAIL t3_det got %0d want 2", rep_det); n_err++; end n_vec++;
  endtask

  task automatic test_min_acc;
    for (int i = 0; i < 512; i++) stim[i] = beat(i, (i == 0) ? 48'h8000_0000_0000 : 48'd0);
    run_frame(512, 0, 100, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, -1);
    if (rep_lane !== 10'd0) begin $display("FAIL t4_lane got %0d want 0", rep_lane); n_err++; end n_vec++;
    if (rep_mag !== 48'h7FFF_FFFF_FFFF) begin $display("FAIL t4_mag got %h want 7fffffffffff", rep_mag); n_err++; end n_vec++;
    if (rep_det !== 10'd0) begin $display("FAIL t4_det got %0d want 0", rep_det); n_err++; end n_vec++;
    if (rep_err !== 1'b0) begin $display("FAIL t4_err got %b want 0", rep_err); n_err++; end n_vec++;
  endtask

  task automatic test_integrity;
    fill_ramp(300);
    run_frame(300, 0, 100, 48'd250, 48'd0, -1);
    if (rep_err !== 1'b1) begin $display("FAIL t5a_err got %b want 1", rep_err); n_err++; end n_vec++;
    if (rep_det !== 10'd50) begin $display("FAIL t5a_det got %0d want 50", rep_det); n_err++; end n_vec++;
    if (rep_lane !== 10'd299 || rep_mag !== 48'd299) begin $display("FAIL t5a_peak got lane %0d mag %0d want 299/299", rep_lane, rep_mag); n_err++; end n_vec++;
    for (int i = 0; i < 512; i++) stim[i] = beat((i < 5) ? i : i + 1, 48'((i < 5) ? i : i + 1));
    run_frame(512, 0, 100, 48'd0, 48'd0, -1);
    if (rep_err !== 1'b1) begin $display("FAIL t5b_err got %b want 1", rep_err); n_err++; end n_vec++;
    if (rep_det !== 10'd512) begin $display("FAIL t5b_det got %0d want 512", rep_det); n_err++; end n_vec++;
    if (rep_lane !== 10'd512) begin $display("FAIL t5b_lane got %0d want 512", rep_lane); n_err++; end n_vec++;
    fill_ramp(600);
    run_frame(600, 0, 100, 48'd0, 48'd0, -1);
    if (rep_cnt != 1) begin $display("FAIL t5c_reports got %0d want 1", rep_cnt); n_err++; end n_vec++;
    if (rep_err !== 1'b1) begin $display("FAIL t5c_err got %b want 1", rep_err); n_err++; end n_vec++;
    if (rep_det !== 10'd600 || rep_lane !== 10'd599) begin $display("FAIL t5c_stats got det %0d lane %0d want 600/599", rep_det, rep_lane); n_err++; end n_vec++;
  endtask

  task automatic test_random_and_reset;
    int bad;
    int spurious;
    fill_ramp(512);
    run_frame(512, 30, 50, 48'd500, 48'd500, 200);
    if (rep_cnt != 0) begin $display("FAIL t6_early_report got %0d want 0", rep_cnt); n_err++; end n_vec++;
    @(negedge clk);
    rst_n = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    #1;
    if (m_axis_tvalid !== 1'b0 || o_busy !== 1'b0) begin $display("FAIL t6_rst_state got mvalid %b busy %b want 0/0", m_axis_tvalid, o_busy); n_err++; end n_vec++;
    spurious = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      #1;
      if (o_report_valid || m_axis_tvalid) spurious++;
    end
    if (spurious != 0) begin $display("FAIL t6_after_reset got %0d active cycles want 0", spurious); n_err++; end n_vec++;
    run_frame(512, 30, 50, 48'd500, 48'd0, -1);
    if (rep_lane !== 10'd511 || rep_mag !== 48'd511) begin $display("FAIL t6_peak got lane %0d mag %0d want 511/511", rep_lane, rep_mag); n_err++; end n_vec++;
    if (rep_det !== 10'd12) begin $display("FAIL t6_det got %0d want 12", rep_det); n_err++; end n_vec++;
    if (rep_err !== 1'b0) begin $display("FAIL t6_err got %b want 0", rep_err); n_err++; end n_vec++;
    if (rep_cnt != 1) begin $display("FAIL t6_reports got %0d want 1", rep_cnt); n_err++; end n_vec++;
    if (out_q.size() != 512) begin $display("FAIL t6_out_count got %0d want 512", out_q.size()); n_err++; end n_vec++;
    bad = 0;
    for (int i = 0; i < out_q.size() && i < 512; i++) begin
      if (out_q[i] !== {(i == 511), stim[i]}) begin
        if (bad < 4) $display("FAIL t6_beat%0d got %h want %h", i, out_q[i], {(i == 511), stim[i]});
        bad++; n_err++;
      end
      n_vec++;
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_negative_peak();
    test_tie();
    test_min_acc();
    test_integrity();
    test_random_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
